// File: rtl/video_capture_rx.sv
// video_capture_rx: rebuilds a 1-bit-per-pixel frame from the SoC videoSync/videoPixel pair as byte writes.
// Latency: inputs registered once; a byte's write strobe follows its 8th pixel sample by one cycle.
// Backpressure: none; the capture RAM must take every strobe. enable=0 drops to IDLE with no writes.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   enable              1 = capture; 0 = return to IDLE, drop partial byte, clear locked
//   videoSync           sync from the SoC (active high, same clock domain)
//   videoPixel          pixel from the SoC (1 = lit)
//   wr_en/addr/data     one-cycle byte write: addr = line*(H_PIXELS/8) + byte, first pixel in bit 7
//   frame_done          pulse: vsync after exactly V_LINES complete lines
//   frame_err           pulse: vsync after a short or aborted frame
//   locked              set by a vsync that starts capture or closes a good frame, cleared by frame_err/!enable

module video_capture_rx #(
  parameter int H_PIXELS    = 64,
  parameter int V_LINES     = 64,
  parameter int PIX_DIV     = 4,
  parameter int H_BACKPORCH = 16,
  parameter int V_BACKPORCH = 8,
  parameter int HSYNC_MIN   = 8,
  parameter int VSYNC_MIN   = 256,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              videoSync,
  input  logic              videoPixel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              locked
);

  localparam int WCNT_W = $clog2(VSYNC_MIN + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam int SKIP_W = $clog2(V_BACKPORCH + 2);
  localparam int HCNT_W = $clog2(H_BACKPORCH + 1);
  localparam int PIX_W  = $clog2(H_PIXELS + 1);
  localparam int PH_W   = $clog2(PIX_DIV);

  localparam logic [WCNT_W-1:0] HS_MIN_L = WCNT_W'(HSYNC_MIN);
  localparam logic [WCNT_W-1:0] VS_MIN_L = WCNT_W'(VSYNC_MIN);
  localparam logic [LINE_W-1:0] LINES_L  = LINE_W'(V_LINES);
  localparam logic [SKIP_W-1:0] SKIP_L   = SKIP_W'(V_BACKPORCH);
  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(H_PIXELS - 1);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(PIX_DIV - 1);
  localparam logic [PH_W-1:0]   PH_MID   = PH_W'(PIX_DIV / 2);
  localparam logic [ADDR_W-1:0] BPL_A    = ADDR_W'(H_PIXELS / 8);
  // The hsync event reaches the FSM two cycles after the release seen at the pins
  // (input register + release-edge classification), and HBP->ACTIVE adds one more,
  // so HBP is shortened by three to line phase 0 up with the first pixel cell.
  localparam logic [HCNT_W-1:0] HBP_LAST = HCNT_W'(H_BACKPORCH - 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VBP,
    S_HWAIT,
    S_HBP,
    S_ACTIVE
  } state_t;

  state_t state, state_n;

  logic              sync_q, pix_q;
  logic [WCNT_W-1:0] wcnt;
  logic              hs_evt, vs_evt;

  logic [LINE_W-1:0] line, line_n;
  logic [SKIP_W-1:0] skip, skip_n;
  logic [HCNT_W-1:0] hcnt, hcnt_n;
  logic [PH_W-1:0]   phase, phase_n;
  logic [PIX_W-1:0]  pcnt, pcnt_n;
  logic [6:0]        sh, sh_n;

  logic              wr_en_n, done_n, err_n, locked_n, frame_chk;
  logic [ADDR_W-1:0] wr_addr_n, line_base;
  logic [7:0]        wr_data_n;

  assign line_base = ADDR_W'(line) * BPL_A;

  // Input register: one cycle of latency on both video inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
      pix_q  <= 1'b0;
    end else begin
      sync_q <= videoSync;
      pix_q  <= videoPixel;
    end
  end

  // Sync width classifier: counts asserted cycles (saturating), classifies on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt   <= '0;
      hs_evt <= 1'b0;
      vs_evt <= 1'b0;
    end else if (!enable) begin
      wcnt   <= '0;
      hs_evt <= 1'b0;
      vs_evt <= 1'b0;
    end else begin
      hs_evt <= 1'b0;
      vs_evt <= 1'b0;
      if (sync_q) begin
        if (wcnt != VS_MIN_L) wcnt <= wcnt + 1'b1;
      end else if (wcnt != '0) begin
        vs_evt <= (wcnt >= VS_MIN_L);
        hs_evt <= (wcnt >= HS_MIN_L) && (wcnt < VS_MIN_L);
        wcnt   <= '0;
      end
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      line       <= '0;
      skip       <= '0;
      hcnt       <= '0;
      phase      <= '0;
      pcnt       <= '0;
      sh         <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      line       <= line_n;
      skip       <= skip_n;
      hcnt       <= hcnt_n;
      phase      <= phase_n;
      pcnt       <= pcnt_n;
      sh         <= sh_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      frame_done <= done_n;
      frame_err  <= err_n;
      locked     <= locked_n;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_n   = state;
    line_n    = line;
    skip_n    = skip;
    hcnt_n    = hcnt;
    phase_n   = phase;
    pcnt_n    = pcnt;
    sh_n      = sh;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    done_n    = 1'b0;
    err_n     = 1'b0;
    locked_n  = locked;
    frame_chk = 1'b0;

    case (state)
      S_IDLE: begin
        if (vs_evt) begin
          state_n  = S_VBP;
          line_n   = '0;
          skip_n   = '0;
          locked_n = 1'b1;
        end
      end
      S_VBP: begin
        if (vs_evt)                frame_chk = 1'b1;
        else if (skip == SKIP_L)   state_n   = S_HWAIT;
        else if (hs_evt)           skip_n    = skip + 1'b1;
      end
      S_HWAIT: begin
        if (vs_evt) begin
          frame_chk = 1'b1;
        end else if (hs_evt && (line < LINES_L)) begin
          state_n = S_HBP;
          hcnt_n  = '0;
        end
      end
      S_HBP: begin
        if (vs_evt) begin
          frame_chk = 1'b1;
        end else if (hcnt == HBP_LAST) begin
          state_n = S_ACTIVE;
          phase_n = '0;
          pcnt_n  = '0;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (vs_evt) begin
          frame_chk = 1'b1;
        end else if (sync_q) begin
          // Sync arriving mid-line aborts it: the partial byte is simply never
          // written and the line counter is left alone so the line is retaken.
          state_n = S_HWAIT;
        end else begin
          phase_n = (phase == PH_LAST) ? '0 : phase + 1'b1;
          if (phase == PH_MID) begin
            sh_n   = {sh[5:0], pix_q};
            pcnt_n = pcnt + 1'b1;
            if (pcnt[2:0] == 3'd7) begin
              wr_en_n   = 1'b1;
              wr_addr_n = line_base + ADDR_W'(pcnt >> 3);
              wr_data_n = {sh, pix_q};
            end
            if (pcnt == PIX_LAST) begin
              line_n  = line + 1'b1;
              state_n = S_HWAIT;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A vsync inside a frame closes it and immediately opens the next one.
    if (frame_chk) begin
      if (line == LINES_L) begin
        done_n   = 1'b1;
        locked_n = 1'b1;
      end else begin
        err_n    = 1'b1;
        locked_n = 1'b0;
      end
      state_n = S_VBP;
      line_n  = '0;
      skip_n  = '0;
    end

    if (!enable) begin
      state_n  = S_IDLE;
      locked_n = 1'b0;
      wr_en_n  = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b0;
    end
  end

endmodule
